// File: rtl/axi_aw_w_scheduler.sv
// Round-robin AW arbiter with grant-order FIFO and W-beat steering for the shared AXI write port.
// Optional macro AXI_AW_W_SCHED_BYPASS_EN: same-cycle AW->W fall-through while the order FIFO is empty.
module axi_aw_w_scheduler #(
    parameter  int unsigned NrPorts        = 3,
    parameter  int unsigned MaxOutstanding = 4,
    localparam int unsigned SelWidth       = $clog2(NrPorts),
    localparam int unsigned PtrWidth       = $clog2(MaxOutstanding),
    localparam int unsigned CntWidth       = PtrWidth + 1
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [NrPorts-1:0]  aw_valid_i,
    output logic [NrPorts-1:0]  aw_ready_o,
    output logic                aw_valid_o,
    input  logic                aw_ready_i,
    output logic [SelWidth-1:0] aw_sel_o,
    input  logic [NrPorts-1:0]  w_valid_i,
    input  logic [NrPorts-1:0]  w_last_i,
    output logic [NrPorts-1:0]  w_ready_o,
    output logic                w_valid_o,
    output logic                w_last_o,
    input  logic                w_ready_i,
    output logic [SelWidth-1:0] w_sel_o,
    output logic                busy_o,
    output logic [CntWidth-1:0] pending_o
);

    // Handshakes: a transfer happens in a cycle where valid and ready are both high; once
    // aw_valid_o is raised it stays up with the same aw_sel_o until aw_ready_i is seen.
    typedef enum logic {
        AW_OPEN   = 1'b0,
        AW_LOCKED = 1'b1
    } aw_state_e;

    aw_state_e           aw_state_q, aw_state_d;
    logic [SelWidth-1:0] held_q, held_d;
    logic [SelWidth-1:0] rr_q, rr_d;
    logic [SelWidth-1:0] fifo_q [MaxOutstanding];
    logic [PtrWidth-1:0] wptr_q, rptr_q;
    logic [CntWidth-1:0] cnt_q, cnt_d;

    logic                fifo_empty;
    logic                fifo_full;
    logic                req_found;
    logic [SelWidth-1:0] req_idx;
    logic [SelWidth-1:0] head;
    logic                aw_hs;
    logic                w_hs_last;
    logic                bypass_hit;
    logic                push;
    logic                pop;

    assign fifo_empty = (cnt_q == '0);
    assign fifo_full  = (cnt_q == CntWidth'(MaxOutstanding));
    assign head       = fifo_q[rptr_q];

    // Scan downward so the last hit is the first requester at or above rr_q (with wrap).
    always_comb begin
        logic [SelWidth-1:0] cand;
        cand      = '0;
        req_found = 1'b0;
        req_idx   = '0;
        for (int i = int'(NrPorts) - 1; i >= 0; i--) begin
            cand = SelWidth'((int'(rr_q) + i) % int'(NrPorts));
            if (aw_valid_i[cand]) begin
                req_found = 1'b1;
                req_idx   = cand;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            aw_state_q <= AW_OPEN;
            held_q     <= '0;
        end else begin
            aw_state_q <= aw_state_d;
            held_q     <= held_d;
        end
    end

    always_comb begin
        aw_state_d = aw_state_q;
        held_d     = held_q;
        case (aw_state_q)
            AW_OPEN: begin
                if (aw_valid_o && !aw_ready_i) begin
                    aw_state_d = AW_LOCKED;
                    held_d     = aw_sel_o;
                end
            end
            AW_LOCKED: begin
                if (aw_ready_i) begin
                    aw_state_d = AW_OPEN;
                end
            end
            default: aw_state_d = AW_OPEN;
        endcase
    end

    // A full FIFO blocks AW even when a pop lands in the same cycle.
    always_comb begin
        aw_valid_o = 1'b0;
        aw_sel_o   = '0;
        aw_ready_o = '0;
        if (rst_ni && !fifo_full) begin
            if (aw_state_q == AW_LOCKED) begin
                aw_valid_o = 1'b1;
                aw_sel_o   = held_q;
            end else if (req_found) begin
                aw_valid_o = 1'b1;
                aw_sel_o   = req_idx;
            end
        end
        if (aw_valid_o) begin
            aw_ready_o[aw_sel_o] = aw_ready_i;
        end
    end

    assign aw_hs = aw_valid_o & aw_ready_i;

`ifdef AXI_AW_W_SCHED_BYPASS_EN
    assign bypass_hit = fifo_empty & aw_hs;
`else
    assign bypass_hit = 1'b0;
`endif

    always_comb begin
        w_sel_o   = '0;
        w_valid_o = 1'b0;
        w_last_o  = 1'b0;
        w_ready_o = '0;
        if (!fifo_empty || bypass_hit) begin
            w_sel_o              = fifo_empty ? aw_sel_o : head;
            w_valid_o            = w_valid_i[w_sel_o];
            w_last_o             = w_last_i[w_sel_o];
            w_ready_o[w_sel_o]   = w_ready_i;
        end
    end

    assign w_hs_last = w_valid_o & w_ready_i & w_last_o;
    assign pop       = w_hs_last & ~fifo_empty;
    // A burst that completes in its own AW cycle never needs an order entry.
    assign push      = aw_hs & ~(bypass_hit & w_hs_last);

    always_comb begin
        cnt_d = cnt_q;
        if (push && !pop) begin
            cnt_d = cnt_q + CntWidth'(1);
        end else if (!push && pop) begin
            cnt_d = cnt_q - CntWidth'(1);
        end
    end

    always_comb begin
        rr_d = rr_q;
        if (aw_hs) begin
            rr_d = (aw_sel_o == SelWidth'(NrPorts - 1)) ? '0 : aw_sel_o + SelWidth'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_q   <= '0;
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
            for (int i = 0; i < int'(MaxOutstanding); i++) begin
                fifo_q[i] <= '0;
            end
        end else begin
            rr_q  <= rr_d;
            cnt_q <= cnt_d;
            if (push) begin
                fifo_q[wptr_q] <= aw_sel_o;
                wptr_q         <= wptr_q + PtrWidth'(1);
            end
            if (pop) begin
                rptr_q <= rptr_q + PtrWidth'(1);
            end
        end
    end

    assign pending_o = cnt_q;
    assign busy_o    = (cnt_q != '0) | aw_valid_o;

`ifndef SYNTHESIS
    // The locked requester must keep its request up until the handshake.
    lock_hold_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (aw_state_q == AW_LOCKED) |-> aw_valid_i[held_q]);
`endif

endmodule

// File: tb/tb_axi_aw_w_scheduler.sv
// Directed bench for axi_aw_w_scheduler: reset, round-robin, lock, ordering, full/pop and bypass.
module tb_axi_aw_w_scheduler;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic [2:0] aw_valid_i;
    logic [2:0] aw_ready_o;
    logic       aw_valid_o;
    logic       aw_ready_i;
    logic [1:0] aw_sel_o;
    logic [2:0] w_valid_i;
    logic [2:0] w_last_i;
    logic [2:0] w_ready_o;
    logic       w_valid_o;
    logic       w_last_o;
    logic       w_ready_i;
    logic [1:0] w_sel_o;
    logic       busy_o;
    logic [2:0] pending_o;

    int checks = 0;
    int errors = 0;
    logic [1:0] exp_q[$];
    logic [1:0] exp_sel;

    axi_aw_w_scheduler #(.NrPorts(3), .MaxOutstanding(4)) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .aw_valid_i (aw_valid_i),
        .aw_ready_o (aw_ready_o),
        .aw_valid_o (aw_valid_o),
        .aw_ready_i (aw_ready_i),
        .aw_sel_o   (aw_sel_o),
        .w_valid_i  (w_valid_i),
        .w_last_i   (w_last_i),
        .w_ready_o  (w_ready_o),
        .w_valid_o  (w_valid_o),
        .w_last_o   (w_last_o),
        .w_ready_i  (w_ready_i),
        .w_sel_o    (w_sel_o),
        .busy_o     (busy_o),
        .pending_o  (pending_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic [31:0] outs();
        return {15'd0, aw_ready_o, aw_valid_o, aw_sel_o, w_ready_o, w_valid_o, w_last_o,
                w_sel_o, busy_o, pending_o};
    endfunction

    initial begin
        rst_ni = 1'b0; aw_valid_i = '0; aw_ready_i = 1'b0;
        w_valid_i = '0; w_last_i = '0; w_ready_i = 1'b0;
        #2;
        check("reset_outputs", outs(), 0);
        tick(); tick();
        rst_ni = 1'b1;

        // Reset mid-burst
        aw_valid_i = 3'b010; aw_ready_i = 1'b1; #1;
        check("a_aw_valid", aw_valid_o, 1);
        check("a_aw_sel", aw_sel_o, 1);
        check("a_aw_ready", aw_ready_o, 3'b010);
        check("a_w_ready_idle", w_ready_o, 0);
        tick();
        aw_valid_i = '0; aw_ready_i = 1'b0; w_valid_i = 3'b010; w_ready_i = 1'b1; #1;
        check("a_pending1", pending_o, 1);
        check("a_w_sel", w_sel_o, 1);
        check("a_w_ready", w_ready_o, 3'b010);
        tick(); tick();
        aw_valid_i = 3'b100; aw_ready_i = 1'b1; rst_ni = 1'b0; #1;
        check("a_reset_outputs", outs(), 0);
        tick();
        w_valid_i = '0; rst_ni = 1'b1; #1;
        check("a_post_pending", pending_o, 0);
        check("a_post_aw_valid", aw_valid_o, 1);
        check("a_post_aw_sel", aw_sel_o, 2);
        tick();
        aw_valid_i = '0; w_valid_i = 3'b100; w_last_i = 3'b100; #1;
        check("a_drain_sel", w_sel_o, 2);
        check("a_drain_last", w_last_o, 1);
        tick();
        w_valid_i = '0; w_last_i = '0; #1;
        check("a_drain_pending", pending_o, 0);

        // Round-robin fill to full
        aw_valid_i = 3'b111; aw_ready_i = 1'b1;
        exp_q = '{2'd0, 2'd1, 2'd2, 2'd0};
        for (int k = 0; k < 4; k++) begin
            #1;
            exp_sel = exp_q.pop_front();
            check("rr_sel", aw_sel_o, exp_sel);
            check("rr_pending", pending_o, k);
            tick();
        end
        #1;
        check("rr_full_aw_valid", aw_valid_o, 0);
        check("rr_full_aw_ready", aw_ready_o, 0);
        check("rr_full_pending", pending_o, 4);
        check("rr_full_busy", busy_o, 1);

        // Full with simultaneous pop
        aw_valid_i = 3'b001; w_valid_i = 3'b001; w_last_i = 3'b001; w_ready_i = 1'b1; #1;
        check("fp_aw_valid", aw_valid_o, 0);
        check("fp_aw_ready", aw_ready_o, 0);
        check("fp_w_ready", w_ready_o, 3'b001);
        tick();
        w_valid_i = '0; w_last_i = '0; #1;
        check("fp_pending3", pending_o, 3);
        check("fp_aw_valid_next", aw_valid_o, 1);
        check("fp_aw_sel_next", aw_sel_o, 0);
        tick();
        aw_valid_i = '0; #1;
        check("fp_pending4", pending_o, 4);
        check("fp_aw_valid_full", aw_valid_o, 0);
        w_valid_i = 3'b111; w_last_i = 3'b111;
        exp_q = '{2'd1, 2'd2, 2'd0, 2'd0};
        for (int k = 0; k < 4; k++) begin
            #1;
            exp_sel = exp_q.pop_front();
            check("fp_drain_sel", w_sel_o, exp_sel);
            tick();
        end
        w_valid_i = '0; w_last_i = '0; #1;
        check("fp_drain_pending", pending_o, 0);
        check("fp_drain_busy", busy_o, 0);

        // AW stability: pointer sits at 1, port 0 granted alone then port 1 joins
        aw_ready_i = 1'b0; aw_valid_i = 3'b001; #1;
        check("st_sel_c1", aw_sel_o, 0);
        check("st_ready_c1", aw_ready_o, 0);
        tick();
        aw_valid_i = 3'b011; #1;
        check("st_sel_c2", aw_sel_o, 0);
        tick(); #0;
        check("st_sel_c3", aw_sel_o, 0);
        tick();
        aw_ready_i = 1'b1; #1;
        check("st_sel_hs", aw_sel_o, 0);
        check("st_ready_hs", aw_ready_o, 3'b001);
        tick();
        #1;
        check("st_next_grant", aw_sel_o, 1);
        tick();
        aw_valid_i = '0; #1;
        check("st_pending", pending_o, 2);
        w_valid_i = 3'b011; w_last_i = 3'b011; #1;
        check("st_w_sel0", w_sel_o, 0);
        tick();
        #1;
        check("st_w_sel1", w_sel_o, 1);
        tick();
        w_valid_i = '0; w_last_i = '0; #1;
        check("st_drain_pending", pending_o, 0);

        // W ordering: port 2 (4 beats) then port 1 (1 beat)
        aw_valid_i = 3'b110; aw_ready_i = 1'b1; #1;
        check("wo_aw_sel2", aw_sel_o, 2);
        tick();
        aw_valid_i = 3'b010; #1;
        check("wo_aw_sel1", aw_sel_o, 1);
        tick();
        aw_valid_i = '0; w_valid_i = 3'b010; w_last_i = 3'b010; #1;
        check("wo_w_sel_head", w_sel_o, 2);
        check("wo_w_ready_hold", w_ready_o, 3'b100);
        check("wo_w_valid_hold", w_valid_o, 0);
        tick();
        w_valid_i = 3'b110;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("wo_beat_ready", w_ready_o, 3'b100);
            check("wo_beat_pending", pending_o, 2);
            tick();
        end
        w_last_i = 3'b110; #1;
        check("wo_last_beat", w_last_o, 1);
        check("wo_last_ready", w_ready_o, 3'b100);
        tick();
        #1;
        check("wo_p1_sel", w_sel_o, 1);
        check("wo_p1_ready", w_ready_o, 3'b010);
        check("wo_p1_pending", pending_o, 1);
        tick();
        w_valid_i = '0; w_last_i = '0; #1;
        check("wo_end_pending", pending_o, 0);

        // Bypass / one-cycle AW-to-W bubble
        aw_valid_i = 3'b010; aw_ready_i = 1'b1;
        w_valid_i = 3'b010; w_last_i = 3'b010; w_ready_i = 1'b1; #1;
`ifdef AXI_AW_W_SCHED_BYPASS_EN
        check("by_w_ready", w_ready_o, 3'b010);
        check("by_w_valid", w_valid_o, 1);
        tick();
        aw_valid_i = '0; w_valid_i = '0; w_last_i = '0; #1;
        check("by_pending", pending_o, 0);
`else
        check("by_w_ready", w_ready_o, 0);
        check("by_w_valid", w_valid_o, 0);
        tick();
        aw_valid_i = '0; #1;
        check("by_pending1", pending_o, 1);
        check("by_w_ready_late", w_ready_o, 3'b010);
        tick();
        w_valid_i = '0; w_last_i = '0; #1;
        check("by_pending0", pending_o, 0);
`endif
        check("end_busy", busy_o, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi_aw_w_scheduler.md
Name: axi_aw_w_scheduler

Overview:
- Write-path controller for the cache subsystem's shared AXI master port.
- Round-robin arbitrates AW requests from NrPorts requesters (icache, bypass, dcache) and records the grant order in an internal order FIFO.
- Steers W beats from the requester at the FIFO head until its last beat.
- Drives select and handshake signals only; AW/W payload muxing stays outside the block and uses aw_sel_o/w_sel_o.

Parameters:
NrPorts, 3, number of write requesters (>=2)
MaxOutstanding, 4, order FIFO depth = max AW granted whose W burst is not yet complete (power of 2)
SelWidth, $clog2(NrPorts), width of select outputs (derived, not overridable)

Ports:
clk_i  in  1  clock, rising edge
rst_ni  in  1  asynchronous active-low reset
aw_valid_i  in  NrPorts  per-requester AW valid
aw_ready_o  out  NrPorts  per-requester AW ready
aw_valid_o  out  1  AW valid to memory
aw_ready_i  in  1  AW ready from memory
aw_sel_o  out  SelWidth  index of requester whose AW payload is forwarded
w_valid_i  in  NrPorts  per-requester W valid
w_last_i  in  NrPorts  per-requester W last
w_ready_o  out  NrPorts  per-requester W ready
w_valid_o  out  1  W valid to memory
w_last_o  out  1  W last to memory
w_ready_i  in  1  W ready from memory
w_sel_o  out  SelWidth  index of requester whose W payload is forwarded
busy_o  out  1  outstanding write activity
pending_o  out  $clog2(MaxOutstanding)+1  order FIFO fill level

Behaviour:
- Reset (async, rst_ni=0):
  - All outputs 0.
  - RR pointer = 0; FIFO empty; AW lock cleared.
- AW arbitration:
  - When unlocked and FIFO not full, grant the first requester with aw_valid_i set, searching from the RR pointer upward and wrapping modulo NrPorts.
  - aw_valid_o = 1 and aw_sel_o = grant index, combinationally, in the same cycle.
  - aw_ready_o[grant] = aw_ready_i; all other aw_ready_o bits are 0.
- AW stability:
  - If aw_valid_o=1 and aw_ready_i=0, set the lock and hold the granted index in a register.
  - While locked, keep presenting the held index regardless of other requests until the handshake completes.
- On AW handshake (aw_valid_o & aw_ready_i):
  - Push the grant index into the FIFO.
  - RR pointer := (grant+1) mod NrPorts.
  - Clear the lock.
- FIFO full:
  - aw_valid_o=0 and all aw_ready_o=0, even if a pop occurs in the same cycle (no push-while-full).
  - A lock cannot be active when the FIFO is full, because a lock is only taken while aw_valid_o is asserted.
- W steering:
  - FIFO non-empty: w_sel_o = head; w_valid_o = w_valid_i[head]; w_last_o = w_last_i[head]; w_ready_o[head] = w_ready_i; other w_ready_o bits 0.
  - FIFO empty: w_valid_o=0, all w_ready_o=0, w_sel_o=0. W data presented before its AW is stalled.
- Pop: on w_valid_o & w_ready_i & w_last_o. Push and pop in the same cycle (FIFO not full) leaves the level unchanged.
- pending_o = FIFO fill level; range 0..MaxOutstanding.
- busy_o = (pending_o != 0) | aw_valid_o.
- Requester dropping aw_valid_i while locked: protocol violation. Lock is held anyway; flag with a simulation-only assertion.
- No flush input: transactions already accepted always drain.

Optional Feature:
- Macro: AXI_AW_W_SCHED_BYPASS_EN.
- Defined:
  - When the FIFO is empty and an AW handshake occurs in the same cycle, W steering falls through to that grant index. w_sel_o and w_ready_o then follow the granted port in that cycle, removing the one-cycle AW-to-W bubble.
  - If that same-cycle W beat has last=1 and is accepted, the push is suppressed; the FIFO stays empty.
- Undefined: W is steered only from the registered FIFO head; at least one idle cycle between AW acceptance and the first W acceptance.

Test Plan:
- Reset mid-burst: AW from port 1 accepted, 2 of 4 W beats sent, assert rst_ni=0 → all outputs 0 immediately; after release pending_o=0, a new AW from port 2 is granted first (pointer back to 0, port 2 is the only requester).
- Round-robin: aw_valid_i=3'b111 held, aw_ready_i=1 → grant order 0,1,2,0; pending_o increments to 4, then aw_valid_o=0 while full.
- AW stability: port 0 requests with aw_ready_i=0 for 3 cycles while port 1 also requests → aw_sel_o stays 0 all 3 cycles; on ready, port 0 is pushed and the next grant goes to port 1.
- W ordering: AWs granted in order 2 then 1 with 4-beat and 1-beat bursts; port 1 asserts w_valid_i first → w_ready_o[1]=0 until port 2's last beat is popped, then port 1's beat passes; pending_o ends at 0.
- Full with simultaneous pop: FIFO at 4, last beat of head accepted while port 0 requests → no AW grant in that cycle, grant in the next, pending_o goes 4→3→4.
- Bypass (macro defined): FIFO empty, port 1 AW and single-beat W with last=1 both valid, both readies 1 → both accepted in the same cycle, pending_o stays 0. Macro undefined → W is accepted one cycle later.
